ahbmtx_l1_rr_arbiter: RTL

AHBMTX_L1_RR_ARBITER -- requirements
Module: ahbmtx_l1_rr_arbiter

---
 rtl/ahbmtx_l1_rr_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ahbmtx_l1_rr_arbiter.sv
// Three-port round-robin address/data-phase arbiter for one AHB matrix slave.
// Optional lock support is compiled in with AHBMTX_L1_LOCK_EN.
module ahbmtx_l1_rr_arbiter (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic [2:0] req_port,
  input  logic       HREADYM,
  input  logic [1:0] HTRANSM,
  input  logic [2:0] HBURSTM,
  input  logic       HMASTLOCKM,
  output logic [1:0] addr_in_port,
  output logic       no_port,
  output logic [1:0] data_in_port,
  output logic       data_valid
);

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_BUSY   = 2'd1;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

`ifdef AHBMTX_L1_LOCK_EN
  typedef enum logic [1:0] {ARB, BURST, LOCK} state_t;
`else
  typedef enum logic [1:0] {ARB, BURST} state_t;
  logic lock_unused;
  assign lock_unused = HMASTLOCKM;
`endif

  state_t      state, state_n;
  logic [3:0]  beat_cnt, cnt_n;
  logic [1:0]  last_grant;
  logic [1:0]  win;
  logic [2:0]  cand;
  logic        any_req;
  logic        rearb;
  logic        fixed_burst;
  logic [3:0]  burst_load;

  // Round-robin search: iterate from farthest to nearest so the nearest
  // requester after last_grant is the one left in win.
  always_comb begin
    any_req = |req_port;
    win     = '0;
    cand    = '0;
    for (int unsigned k = 3; k >= 1; k--) begin
      cand = {1'b0, last_grant} + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (req_port[cand[1:0]]) win = cand[1:0];
    end
  end

  always_comb begin
    fixed_burst = (HBURSTM[2:1] != 2'b00);
    case (HBURSTM[2:1])
      2'b01:   burst_load = 4'd3;
      2'b10:   burst_load = 4'd7;
      2'b11:   burst_load = 4'd15;
      default: burst_load = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = beat_cnt;
    rearb   = 1'b0;
    case (state)
      ARB: begin
        if (HTRANSM == TR_NONSEQ && fixed_burst) begin
          state_n = BURST;
          cnt_n   = burst_load;
        end else if ((HTRANSM == TR_SEQ || HTRANSM == TR_BUSY) && !no_port) begin
          state_n = ARB;
        end else begin
          rearb = 1'b1;
        end
      end
      BURST: begin
        if (HTRANSM == TR_SEQ) begin
          if (beat_cnt == 4'd1) begin
            cnt_n   = '0;
            state_n = ARB;
            rearb   = 1'b1;
          end else begin
            cnt_n = beat_cnt - 4'd1;
          end
        end else if (HTRANSM != TR_BUSY) begin
          cnt_n   = '0;
          state_n = ARB;
          rearb   = 1'b1;
        end
      end
`ifdef AHBMTX_L1_LOCK_EN
      LOCK: begin
        if (!HMASTLOCKM && HTRANSM == TR_IDLE) begin
          cnt_n   = '0;
          state_n = ARB;
          rearb   = 1'b1;
        end else if (HTRANSM == TR_NONSEQ && fixed_burst) begin
          cnt_n = burst_load;
        end else if (HTRANSM == TR_SEQ && beat_cnt != '0) begin
          cnt_n = beat_cnt - 4'd1;
        end
      end
`endif
      default: begin
        state_n = ARB;
        cnt_n   = '0;
      end
    endcase
`ifdef AHBMTX_L1_LOCK_EN
    // Lock overrides any rearbitration chosen above; burst counting continues.
    if (state != LOCK && HMASTLOCKM && HTRANSM != TR_IDLE) begin
      state_n = LOCK;
      rearb   = 1'b0;
      if (HTRANSM == TR_NONSEQ && fixed_burst) cnt_n = burst_load;
    end
`endif
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state        <= ARB;
      beat_cnt     <= '0;
      last_grant   <= 2'd2;
      addr_in_port <= '0;
      no_port      <= 1'b1;
      data_in_port <= '0;
      data_valid   <= 1'b0;
    end else if (HREADYM) begin
      state        <= state_n;
      beat_cnt     <= cnt_n;
      data_in_port <= addr_in_port;
      data_valid   <= ~no_port & HTRANSM[1];
      if (rearb) begin
        if (any_req) begin
          addr_in_port <= win;
          no_port      <= 1'b0;
          last_grant   <= win;
        end else begin
          no_port      <= 1'b1;
        end
      end
    end
  end

endmodule
